// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM state encoding,
// RV32 opcode constants, immediate format codes and fault codes.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_TIMEOUT = 2'd1;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd2;

  function automatic logic opcode_legal(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_OP: opcode_legal = 1'b1;
      default:                          opcode_legal = 1'b0;
    endcase
  endfunction

  // Illegal opcodes fall back to the I format; their immediate is never used.
  function automatic logic [2:0] imm_sel_of(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC: imm_sel_of = IMM_U;
      OP_JAL:           imm_sel_of = IMM_J;
      OP_BRANCH:        imm_sel_of = IMM_B;
      OP_STORE:         imm_sel_of = IMM_S;
      default:          imm_sel_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_imm_gen.sv
// RV32 immediate generator: expands the instruction word into a 32-bit
// sign-extended immediate for the format chosen by imm_sel.
module imm_gen
  import multicycle_ctrl_pkg::*;
(
  input  logic [31:7] instr,
  input  logic [2:0]  imm_sel,
  output logic [31:0] immediate
);

  always_comb begin
    immediate = 32'd0;
    case (imm_sel)
      IMM_I: immediate = {{20{instr[31]}}, instr[31:20]};
      IMM_S: immediate = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: immediate = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
      IMM_U: immediate = {instr[31:12], 12'd0};
      IMM_J: immediate = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
      default: immediate = 32'd0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) with memory
// wait timeout. Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        branch_taken,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic [2:0]  imm_sel,
  output logic [31:0] immediate,
  output logic        reg_we,
  output logic [1:0]  fault
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic        mem_req_next;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_next;
  logic [2:0]  imm_sel_next;
  logic [1:0]  fault_next;
  logic [6:0]  opcode;
  logic        acked;
  logic        waiting;
  logic        timeout_hit;

  assign opcode  = instr[6:0];
  assign acked   = mem_req && mem_ack;
  assign waiting = mem_req && !mem_ack;
  // An ack in the last allowed wait cycle wins over the timeout.
  assign timeout_hit = waiting && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_FETCH;
      mem_req  <= 1'b0;
      wait_cnt <= 8'd0;
      imm_sel  <= IMM_I;
      fault    <= FAULT_NONE;
    end else begin
      state    <= state_next;
      mem_req  <= mem_req_next;
      wait_cnt <= wait_next;
      imm_sel  <= imm_sel_next;
      fault    <= fault_next;
    end
  end

  // mem_req is registered, so it is raised on the edge that enters FETCH/MEM.
  always_comb begin
    state_next   = state;
    mem_req_next = mem_req;
    wait_next    = waiting ? wait_cnt + 8'd1 : wait_cnt;
    imm_sel_next = imm_sel;
    fault_next   = fault;
    case (state)
      ST_FETCH: begin
        if (!mem_req) begin
          mem_req_next = 1'b1;
        end else if (mem_ack) begin
          state_next   = ST_DECODE;
          mem_req_next = 1'b0;
        end else if (timeout_hit) begin
          state_next   = ST_HALT;
          mem_req_next = 1'b0;
          fault_next   = FAULT_TIMEOUT;
        end
      end
      ST_DECODE: begin
        imm_sel_next = imm_sel_of(opcode);
        if (opcode_legal(opcode)) begin
          state_next = ST_EXEC;
        end else begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          state_next = ST_HALT;
          fault_next = FAULT_ILLEGAL;
`else
          state_next   = ST_FETCH;
          mem_req_next = 1'b1;
          wait_next    = 8'd0;
`endif
        end
      end
      ST_EXEC: begin
        case (opcode)
          OP_BRANCH: begin
            state_next   = ST_FETCH;
            mem_req_next = 1'b1;
            wait_next    = 8'd0;
          end
          OP_LOAD, OP_STORE: begin
            state_next   = ST_MEM;
            mem_req_next = 1'b1;
            wait_next    = 8'd0;
          end
          default: state_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (acked) begin
          if (opcode == OP_STORE) begin
            state_next   = ST_FETCH;
            mem_req_next = 1'b1;
            wait_next    = 8'd0;
          end else begin
            state_next   = ST_WB;
            mem_req_next = 1'b0;
          end
        end else if (timeout_hit) begin
          state_next   = ST_HALT;
          mem_req_next = 1'b0;
          fault_next   = FAULT_TIMEOUT;
        end
      end
      ST_WB: begin
        state_next   = ST_FETCH;
        mem_req_next = 1'b1;
        wait_next    = 8'd0;
      end
      ST_HALT: begin
        mem_req_next = 1'b0;
      end
      default: begin
        state_next   = ST_HALT;
        mem_req_next = 1'b0;
      end
    endcase
  end

  always_comb begin
    ir_we  = 1'b0;
    pc_we  = 1'b0;
    pc_src = 1'b0;
    reg_we = 1'b0;
    mem_we = 1'b0;
    case (state)
      ST_FETCH: begin
        ir_we = acked;
        pc_we = acked;
      end
      ST_EXEC: begin
        case (opcode)
          OP_BRANCH: begin
            pc_we  = branch_taken;
            pc_src = branch_taken;
          end
          OP_JAL, OP_JALR: begin
            pc_we  = 1'b1;
            pc_src = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM:  mem_we = mem_req && (opcode == OP_STORE);
      ST_WB:   reg_we = 1'b1;
      default: ;
    endcase
  end

  imm_gen u_imm_gen (
    .instr     (instr[31:7]),
    .imm_sel   (imm_sel),
    .immediate (immediate)
  );

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum number of cycles to wait for mem_ack per request (range 2..255).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port instr, input, 32 bits, the IR contents, valid from DECODE onward.
REQ-005 SHALL have port branch_taken, input, 1 bit, the ALU compare result, sampled in EXEC.
REQ-006 SHALL have port mem_ack, input, 1 bit, memory completion for the current request.
REQ-007 SHALL have port mem_req, output, 1 bit, memory request, held until acknowledged.
REQ-008 SHALL have port mem_we, output, 1 bit, write request; meaningful only while mem_req=1.
REQ-009 SHALL have port ir_we, output, 1 bit, IR load strobe.
REQ-010 SHALL have port pc_we, output, 1 bit, PC load strobe.
REQ-011 SHALL have port pc_src, output, 1 bit, PC source select: 0=pc+4, 1=ALU target.
REQ-012 SHALL have port imm_sel, output, 3 bits, immediate format select: I=000, S=001, B=010, U=011, J=100.
REQ-013 SHALL have port immediate, output, 32 bits, the generated immediate.
REQ-014 SHALL have port reg_we, output, 1 bit, register-file write strobe.
REQ-015 SHALL have port fault, output, 2 bits, sticky fault code: 0=none, 1=timeout, 2=illegal.

Function
REQ-016 SHALL implement the states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-017 FETCH SHALL drive mem_req=1 and mem_we=0; on mem_ack it SHALL pulse ir_we and pc_we (pc_src=0) for one cycle and go to DECODE.
REQ-018 DECODE SHALL last one cycle, register imm_sel from instr[6:0] and go to EXEC.
REQ-019 The opcode-to-imm_sel map SHALL be:
- LUI 0110111 and AUIPC 0010111 -> U.
- JAL 1101111 -> J.
- JALR 1100111, LOAD 0000011, OP-IMM 0010011 and OP 0110011 -> I.
- BRANCH 1100011 -> B.
- STORE 0100011 -> S.
REQ-020 Any other opcode SHALL be illegal.
REQ-021 imm_sel SHALL hold its value from DECODE until the next DECODE.
REQ-022 EXEC SHALL last one cycle and route by opcode:
- BRANCH: pulse pc_we with pc_src=1 only if branch_taken=1, then go to FETCH.
- JAL/JALR: pulse pc_we with pc_src=1, then go to WB.
- LOAD/STORE: go to MEM.
- All others: go to WB.
REQ-023 MEM SHALL drive mem_req=1, with mem_we=1 for STORE; on mem_ack, LOAD SHALL go to WB and STORE SHALL go to FETCH.
REQ-024 WB SHALL pulse reg_we for one cycle and go to FETCH.
REQ-025 mem_req SHALL rise only on entry to FETCH or MEM and SHALL stay high until the cycle mem_ack=1 is sampled.
REQ-026 mem_ack SHALL be ignored outside FETCH and MEM.
REQ-027 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_req=1 and mem_ack=0.
REQ-028 When the wait counter reaches TIMEOUT_CYCLES, the block SHALL set fault=1, drop mem_req and go to HALT.
REQ-029 If mem_ack=1 arrives in the same cycle the wait counter reaches TIMEOUT_CYCLES, mem_ack SHALL win and no fault SHALL be recorded.
REQ-030 HALT SHALL drive all strobes and mem_req to 0 and SHALL be left only by reset.
REQ-031 fault SHALL never change once non-zero.
REQ-032 Every instruction SHALL take the following minimum cycle counts with single-cycle ack:
- Taken or not-taken branch: 3.
- Store: 4.
- Load: 5.
- ALU, LUI, AUIPC and jumps: 4.

Reset
REQ-033 While rst_n=0, the state SHALL be FETCH with mem_req=0.
REQ-034 While rst_n=0, all outputs SHALL be 0: mem_we, ir_we, pc_we, pc_src, reg_we, imm_sel=000, fault=00 and the wait counter.
REQ-035 On the first clk edge after rst_n rises, mem_req SHALL assert.
REQ-036 Reset asserted mid-transaction SHALL abort it immediately, with no strobe issued.

Configuration
REQ-037 With MULTICYCLE_CTRL_ILLEGAL_TRAP_EN defined, an illegal opcode in DECODE SHALL set fault=2 and go to HALT.
REQ-038 Without MULTICYCLE_CTRL_ILLEGAL_TRAP_EN, an illegal opcode SHALL be treated as a NOP: DECODE goes to FETCH, no reg_we is issued and fault is unaffected.

Structure
REQ-039 A shared package SHALL hold the state encoding, the opcode constants and the imm_sel codes (IMM_I..IMM_J).
REQ-040 The block SHALL instantiate one sub-module, imm_gen, driven by instr and the registered imm_sel, with its output forwarded to immediate.

Verification
REQ-041 addi 0x00500093 with single-cycle ack -> states FETCH, DECODE, EXEC, WB; imm_sel=000; immediate=0x00000005; reg_we high 1 cycle; 4 cycles total.
REQ-042 beq 0xFE000EE3 with branch_taken=1 -> imm_sel=010; immediate=0xFFFFFFFC; pc_we with pc_src=1 in EXEC; next state FETCH; no reg_we.
REQ-043 sw 0x00112223 with mem_ack delayed 3 cycles in MEM -> mem_req and mem_we held high 4 cycles; imm_sel=001; immediate=0x00000004; then FETCH.
REQ-044 TIMEOUT_CYCLES=4 with mem_ack never asserted in FETCH -> fault=1 after 4 cycles; HALT; mem_req=0; strobes stay low until rst_n pulse.
REQ-045 instr=0xFFFFFFFF -> with macro: fault=2 and HALT; without macro: returns to FETCH, reg_we never asserted, fault=0.
REQ-046 rst_n pulsed low mid-MEM -> outputs 0 asynchronously; mem_req reasserts for FETCH on the first edge after release.
